// File: rtl/qc_pipe_if.sv
// qc_pipe_if: handshake bundle for the qc_pipe branch-condition unit.
//   Request side : InValid/InReady, RSbus, RTbus, QCsel, InTag
//   Response side: OutValid/OutReady, Result, Illegal, OutTag
//   master = producer of requests / consumer of results (branch path)
//   slave  = the qc_pipe unit itself
interface qc_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] RSbus;
  logic [WIDTH-1:0] RTbus;
  logic [3:0]       QCsel;
  logic [TAG_W-1:0] InTag;
  logic             OutValid;
  logic             OutReady;
  logic             Result;
  logic             Illegal;
  logic [TAG_W-1:0] OutTag;

  modport master (
    output InValid, RSbus, RTbus, QCsel, InTag, OutReady,
    input  InReady, OutValid, Result, Illegal, OutTag
  );

  modport slave (
    input  InValid, RSbus, RTbus, QCsel, InTag, OutReady,
    output InReady, OutValid, Result, Illegal, OutTag
  );
endinterface

// File: rtl/qc_pipe.sv
// qc_pipe: two-stage pipelined branch-condition unit.
//   Stage 1 registers the operands, condition select and tag on an input
//   handshake; stage 2 registers the evaluated Result/Illegal/OutTag.
//   Ports:
//     Clk, Reset_n (sync, active low), Flush (clears both stages)
//     qc        : qc_pipe_if.slave, request/response handshake bundle
//     StatClr   : zeroes the statistics counters
//     TakenCnt  : saturating count of delivered taken results
//     EvalCnt   : saturating count of delivered results
//   Build option: define QC_STATS_EN to build the statistics counters;
//   otherwise TakenCnt/EvalCnt are tied to zero and StatClr is ignored.
module qc_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Flush,
  input  logic             StatClr,
  qc_pipe_if.slave         qc,
  output logic [CNT_W-1:0] TakenCnt,
  output logic [CNT_W-1:0] EvalCnt
);

  // vld_pipe[1] = stage 1 occupied, vld_pipe[2] = stage 2 occupied
  logic [2:1]       vld_pipe;
  logic [WIDTH-1:0] s1_s, s1_t;
  logic [3:0]       s1_sel;
  logic [TAG_W-1:0] s1_tag;
  logic             s2_res, s2_ill;
  logic [TAG_W-1:0] s2_tag;

  logic s2_adv, in_acc, out_hs;
  logic ev_res, ev_ill;
  logic s_neg, s_zero;

  assign out_hs       = vld_pipe[2] & qc.OutReady;
  assign s2_adv       = ~vld_pipe[2] | qc.OutReady;
  assign qc.InReady   = ~Flush & (~vld_pipe[1] | s2_adv);
  assign in_acc       = qc.InValid & qc.InReady;

  assign qc.OutValid  = vld_pipe[2];
  assign qc.Result    = s2_res;
  assign qc.Illegal   = s2_ill;
  assign qc.OutTag    = s2_tag;

  assign s_neg  = s1_s[WIDTH-1];
  assign s_zero = ~|s1_s;

  // Condition evaluation on the stage-1 registers; result lands in stage 2.
  always_comb begin
    ev_res = 1'b0;
    ev_ill = 1'b0;
    case (s1_sel)
      4'd0:    ev_res = (s1_s != s1_t);
      4'd1:    ev_res = (s1_s == s1_t);
      4'd2:    ev_res = s_neg | s_zero;
      4'd3:    ev_res = ~s_neg & ~s_zero;
      4'd4:    ev_res = ~s_neg;
      4'd5:    ev_res = s_neg;
      4'd6:    ev_res = ($signed(s1_s) <  $signed(s1_t));
      4'd7:    ev_res = ($signed(s1_s) >= $signed(s1_t));
      4'd8:    ev_res = (s1_s <  s1_t);
      4'd9:    ev_res = (s1_s >= s1_t);
      default: ev_ill = 1'b1;
    endcase
  end

  // Valid bits: flush drops everything; stage 1 empties when it moves on
  // and nothing new arrives behind it.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      vld_pipe <= '0;
    end else if (Flush) begin
      vld_pipe <= '0;
    end else begin
      if (s2_adv)      vld_pipe[2] <= vld_pipe[1];
      if (in_acc)      vld_pipe[1] <= 1'b1;
      else if (s2_adv) vld_pipe[1] <= 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_s   <= '0;
      s1_t   <= '0;
      s1_sel <= '0;
      s1_tag <= '0;
    end else if (in_acc) begin
      s1_s   <= qc.RSbus;
      s1_t   <= qc.RTbus;
      s1_sel <= qc.QCsel;
      s1_tag <= qc.InTag;
    end
  end

  // Stage 2 only loads on a transfer, so outputs hold while stalled.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s2_res <= 1'b0;
      s2_ill <= 1'b0;
      s2_tag <= '0;
    end else if (s2_adv & vld_pipe[1]) begin
      s2_res <= ev_res;
      s2_ill <= ev_ill;
      s2_tag <= s1_tag;
    end
  end

`ifdef QC_STATS_EN
  // A delivery coincident with Flush still counts; StatClr beats increment.
  always_ff @(posedge Clk) begin
    if (!Reset_n || StatClr) begin
      TakenCnt <= '0;
      EvalCnt  <= '0;
    end else if (out_hs) begin
      if (EvalCnt != '1)            EvalCnt  <= EvalCnt + CNT_W'(1);
      if (s2_res && TakenCnt != '1) TakenCnt <= TakenCnt + CNT_W'(1);
    end
  end
`else
  logic stat_unused;
  assign stat_unused = StatClr | out_hs;
  assign TakenCnt    = '0;
  assign EvalCnt     = '0;
`endif

endmodule

// File: tb/tb_qc_pipe.sv
// tb_qc_pipe: directed scenarios plus a randomized run scored against a
// queue-based reference model of the branch-condition unit.
module tb_qc_pipe;
  localparam int WIDTH = 32;
  localparam int TAG_W = 4;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef QC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic       res;
    logic       ill;
    logic [3:0] tag;
    int         acc;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic Flush = 1'b0;
  logic StatClr = 1'b0;
  logic [CNT_W-1:0] TakenCnt, EvalCnt;
  int n_chk = 0;
  int n_fail = 0;

  qc_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) qc ();

  qc_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Flush(Flush), .StatClr(StatClr),
    .qc(qc), .TakenCnt(TakenCnt), .EvalCnt(EvalCnt)
  );

  always #5 Clk = ~Clk;

  // Reference: conditions evaluated on mathematical integer values.
  function automatic logic [1:0] ref_eval(input logic [31:0] s, input logic [31:0] t,
                                          input logic [3:0] sel);
    longint ss, st, us, ut;
    bit r;
    ss = longint'($signed(s));
    st = longint'($signed(t));
    us = longint'(s);
    ut = longint'(t);
    case (sel)
      4'd0: r = (us != ut);
      4'd1: r = (us == ut);
      4'd2: r = (ss <= 0);
      4'd3: r = (ss > 0);
      4'd4: r = (ss >= 0);
      4'd5: r = (ss < 0);
      4'd6: r = (ss < st);
      4'd7: r = (ss >= st);
      4'd8: r = (us < ut);
      4'd9: r = (us >= ut);
      default: return 2'b10;
    endcase
    return {1'b0, r};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'h1;
      default: return $urandom();
    endcase
  endfunction

  task automatic tick;
    @(negedge Clk);
  endtask

  task automatic drive(input bit v, input logic [31:0] s, input logic [31:0] t,
                       input logic [3:0] sel, input logic [3:0] tag);
    qc.InValid = v;
    qc.RSbus   = s;
    qc.RTbus   = t;
    qc.QCsel   = sel;
    qc.InTag   = tag;
  endtask

  task automatic test_reset;
    Reset_n = 1'b0; Flush = 1'b0; StatClr = 1'b0;
    qc.OutReady = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (3) tick;
    n_chk++;
    if ({qc.OutValid, qc.Result, qc.Illegal, qc.OutTag} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_out got=%b exp=%b", {qc.OutValid, qc.Result, qc.Illegal, qc.OutTag}, 7'b0);
    end
    n_chk++;
    if ({TakenCnt, EvalCnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0", TakenCnt, EvalCnt);
    end
    Reset_n = 1'b1;
    #1;
    n_chk++;
    if (qc.InReady !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_inready got=%b exp=1", qc.InReady);
    end
  endtask

  task automatic test_basic;
    qc.OutReady = 1'b1;
    drive(1, 5, 5, 4'd0, 4'd3);
    tick;
    drive(1, 5, 5, 4'd1, 4'd4);
    n_chk++;
    if (qc.OutValid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_latency got=%b exp=0", qc.OutValid);
    end
    tick;
    drive(0, 0, 0, 0, 0);
    n_chk++;
    if ({qc.OutValid, qc.Result, qc.Illegal, qc.OutTag} !== {1'b1, 1'b0, 1'b0, 4'd3}) begin
      n_fail++;
      $display("FAIL basic_ne got=%b exp=%b", {qc.OutValid, qc.Result, qc.Illegal, qc.OutTag}, {1'b1, 1'b0, 1'b0, 4'd3});
    end
    tick;
    n_chk++;
    if ({qc.OutValid, qc.Result, qc.Illegal, qc.OutTag} !== {1'b1, 1'b1, 1'b0, 4'd4}) begin
      n_fail++;
      $display("FAIL basic_eq got=%b exp=%b", {qc.OutValid, qc.Result, qc.Illegal, qc.OutTag}, {1'b1, 1'b1, 1'b0, 4'd4});
    end
    tick;
    n_chk++;
    if (qc.OutValid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drain got=%b exp=0", qc.OutValid);
    end
  endtask

  task automatic test_compare;
    logic [31:0] ts [5];
    logic [31:0] tt [5];
    logic [3:0]  tsel [5];
    logic        texp [5];
    ts   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'h0};
    tt   = '{32'h1,         32'h1,         32'h7FFF_FFFF, 32'h0, 32'h0};
    tsel = '{4'd6,          4'd8,          4'd9,          4'd2,  4'd3};
    texp = '{1'b1,          1'b0,          1'b1,          1'b1,  1'b0};
    qc.OutReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1, ts[i], tt[i], tsel[i], 4'(i + 8));
      tick;
      drive(0, 0, 0, 0, 0);
      tick;
      n_chk++;
      if ({qc.OutValid, qc.Result, qc.Illegal, qc.OutTag} !== {1'b1, texp[i], 1'b0, 4'(i + 8)}) begin
        n_fail++;
        $display("FAIL compare_%0d got=%b exp=%b", i, {qc.OutValid, qc.Result, qc.Illegal, qc.OutTag}, {1'b1, texp[i], 1'b0, 4'(i + 8)});
      end
    end
    tick;
  endtask

  task automatic test_backpressure;
    qc.OutReady = 1'b0;
    drive(1, 7, 7, 4'd1, 4'd1);
    tick;
    drive(1, 7, 7, 4'd0, 4'd2);
    #1;
    n_chk++;
    if (qc.InReady !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready2 got=%b exp=1", qc.InReady);
    end
    tick;
    drive(1, 3, 9, 4'd8, 4'd5);
    #1;
    n_chk++;
    if (qc.InReady !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full got=%b exp=0", qc.InReady);
    end
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if ({qc.OutValid, qc.Result, qc.Illegal, qc.OutTag} !== {1'b1, 1'b1, 1'b0, 4'd1}) begin
        n_fail++;
        $display("FAIL bp_stable_%0d got=%b exp=%b", k, {qc.OutValid, qc.Result, qc.Illegal, qc.OutTag}, {1'b1, 1'b1, 1'b0, 4'd1});
      end
      tick;
    end
    qc.OutReady = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick;
    n_chk++;
    if ({qc.OutValid, qc.Result, qc.Illegal, qc.OutTag} !== {1'b1, 1'b0, 1'b0, 4'd2}) begin
      n_fail++;
      $display("FAIL bp_second got=%b exp=%b", {qc.OutValid, qc.Result, qc.Illegal, qc.OutTag}, {1'b1, 1'b0, 1'b0, 4'd2});
    end
    tick;
    n_chk++;
    if (qc.OutValid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_third_dropped got=%b exp=0", qc.OutValid);
    end
  endtask

  task automatic test_flush;
    qc.OutReady = 1'b0;
    drive(1, 1, 1, 4'd1, 4'd6);
    tick;
    drive(1, 1, 2, 4'd0, 4'd7);
    tick;
    Flush = 1'b1;
    drive(1, 4, 4, 4'd1, 4'd9);
    #1;
    n_chk++;
    if ({qc.OutValid, qc.InReady} !== 2'b10) begin
      n_fail++;
      $display("FAIL flush_cycle got=%b exp=10", {qc.OutValid, qc.InReady});
    end
    tick;
    Flush = 1'b0;
    drive(0, 0, 0, 0, 0);
    n_chk++;
    if (qc.OutValid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_cleared got=%b exp=0", qc.OutValid);
    end
    tick;
    n_chk++;
    if (qc.OutValid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_no_accept got=%b exp=0", qc.OutValid);
    end
    qc.OutReady = 1'b1;
    drive(1, 5, 5, 4'd12, 4'd10);
    tick;
    drive(0, 0, 0, 0, 0);
    tick;
    n_chk++;
    if ({qc.OutValid, qc.Result, qc.Illegal, qc.OutTag} !== {1'b1, 1'b0, 1'b1, 4'd10}) begin
      n_fail++;
      $display("FAIL flush_illegal got=%b exp=%b", {qc.OutValid, qc.Result, qc.Illegal, qc.OutTag}, {1'b1, 1'b0, 1'b1, 4'd10});
    end
    tick;
  endtask

  task automatic test_reset_mid;
    qc.OutReady = 1'b0;
    drive(1, 9, 9, 4'd1, 4'd11);
    tick;
    drive(1, 9, 8, 4'd0, 4'd12);
    tick;
    drive(0, 0, 0, 0, 0);
    qc.OutReady = 1'b1;
    Reset_n = 1'b0;
    tick;
    Reset_n = 1'b1;
    n_chk++;
    if ({qc.OutValid, qc.Result, qc.Illegal, qc.OutTag} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_mid got=%b exp=%b", {qc.OutValid, qc.Result, qc.Illegal, qc.OutTag}, 7'b0);
    end
    tick;
  endtask

  task automatic test_stats;
    logic [CNT_W-1:0] e_sat, e_t, e_e;
    e_sat = STATS ? CNT_W'(CMAX) : '0;
    e_t   = STATS ? CNT_W'(1) : '0;
    e_e   = STATS ? CNT_W'(2) : '0;
    qc.OutReady = 1'b1;
    drive(0, 0, 0, 0, 0);
    StatClr = 1'b1;
    tick;
    StatClr = 1'b0;
    n_chk++;
    if ({TakenCnt, EvalCnt} !== '0) begin
      n_fail++;
      $display("FAIL stats_clr0 got=%0d/%0d exp=0/0", TakenCnt, EvalCnt);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'(i), 32'(i), 4'd1, 4'(i));
      tick;
    end
    drive(0, 0, 0, 0, 0);
    repeat (2) tick;
    n_chk++;
    if ({TakenCnt, EvalCnt} !== {e_sat, e_sat}) begin
      n_fail++;
      $display("FAIL stats_sat got=%0d/%0d exp=%0d/%0d", TakenCnt, EvalCnt, e_sat, e_sat);
    end
    drive(1, 2, 2, 4'd1, 4'd1);
    tick;
    drive(0, 0, 0, 0, 0);
    tick;
    StatClr = 1'b1;
    tick;
    StatClr = 1'b0;
    n_chk++;
    if ({qc.OutValid, TakenCnt, EvalCnt} !== {1'b0, {2*CNT_W{1'b0}}}) begin
      n_fail++;
      $display("FAIL stats_clr_hs got=%b/%0d/%0d exp=0/0/0", qc.OutValid, TakenCnt, EvalCnt);
    end
    drive(1, 2, 2, 4'd1, 4'd2);
    tick;
    drive(1, 2, 2, 4'd0, 4'd3);
    tick;
    drive(0, 0, 0, 0, 0);
    repeat (2) tick;
    n_chk++;
    if ({TakenCnt, EvalCnt} !== {e_t, e_e}) begin
      n_fail++;
      $display("FAIL stats_mixed got=%0d/%0d exp=%0d/%0d", TakenCnt, EvalCnt, e_t, e_e);
    end
  endtask

  task automatic test_random;
    exp_t q[$];
    int e, tk, ev;
    bit exp_ov, exp_rdy, acc, hs;
    logic [1:0]  r;
    logic [31:0] s;
    drive(0, 0, 0, 0, 0);
    qc.OutReady = 1'b1;
    StatClr = 1'b1;
    repeat (3) tick;
    StatClr = 1'b0;
    e = 0; tk = 0; ev = 0;
    for (int i = 0; i < 600; i++) begin
      exp_ov = (q.size() > 0) && (q[0].acc != e);
      n_chk++;
      if (qc.OutValid !== exp_ov) begin
        n_fail++;
        $display("FAIL rnd_outvalid cyc=%0d got=%b exp=%b", i, qc.OutValid, exp_ov);
      end
      if (exp_ov) begin
        n_chk++;
        if ({qc.Result, qc.Illegal, qc.OutTag} !== {q[0].res, q[0].ill, q[0].tag}) begin
          n_fail++;
          $display("FAIL rnd_result cyc=%0d got=%b exp=%b", i, {qc.Result, qc.Illegal, qc.OutTag}, {q[0].res, q[0].ill, q[0].tag});
        end
      end
      n_chk++;
      if ({TakenCnt, EvalCnt} !== {CNT_W'(tk), CNT_W'(ev)}) begin
        n_fail++;
        $display("FAIL rnd_counts cyc=%0d got=%0d/%0d exp=%0d/%0d", i, TakenCnt, EvalCnt, tk, ev);
      end
      s = pick();
      drive($urandom_range(0, 9) < 7, s, ($urandom_range(0, 3) == 0) ? s : pick(),
            ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9)),
            4'($urandom));
      qc.OutReady = $urandom_range(0, 9) < 7;
      Flush   = $urandom_range(0, 15) == 0;
      StatClr = $urandom_range(0, 31) == 0;
      #1;
      exp_rdy = !Flush && ((q.size() < 2) || qc.OutReady);
      n_chk++;
      if (qc.InReady !== exp_rdy) begin
        n_fail++;
        $display("FAIL rnd_inready cyc=%0d got=%b exp=%b", i, qc.InReady, exp_rdy);
      end
      acc = qc.InValid && exp_rdy;
      hs  = exp_ov && qc.OutReady;
      e++;
      if (hs) begin
        if (STATS) begin
          if (ev < CMAX) ev++;
          if (q[0].res && tk < CMAX) tk++;
        end
        void'(q.pop_front());
      end
      if (StatClr) begin
        tk = 0;
        ev = 0;
      end
      if (Flush) q.delete();
      if (acc) begin
        r = ref_eval(qc.RSbus, qc.RTbus, qc.QCsel);
        q.push_back('{res: r[0], ill: r[1], tag: qc.InTag, acc: e});
      end
      tick;
    end
    Flush = 1'b0;
    StatClr = 1'b0;
    drive(0, 0, 0, 0, 0);
    qc.OutReady = 1'b1;
    repeat (3) tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_compare;
    test_backpressure;
    test_flush;
    test_reset_mid;
    test_stats;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/qc_pipe.md
# qc_pipe

Pipelined, parametrised branch-condition unit that succeeds the single-cycle quick compare in the MIPS-Lite/DLX branch path. It accepts RS/RT operands, a condition select and a tag under a valid/ready handshake, and evaluates zero-based and register-to-register signed/unsigned conditions over a two-stage pipeline. It supports backpressure and a pipeline flush, and returns a tagged Result to the branch resolution logic. Optional saturating taken/evaluated counters feed performance monitoring.

## Interface
- WIDTH, 32: operand width in bits, at least 2.
- TAG_W, 4: width of the pass-through tag.
- CNT_W, 16: width of the statistics counters.
- Clk  in  1  clock; all state changes on the rising edge.
- Reset_n  in  1  reset, synchronous and active-low.
- Flush  in  1  synchronous flush of both pipeline stages.
- InValid  in  1  input operation valid.
- InReady  out  1  unit can accept an input this cycle.
- RSbus  in  WIDTH  S operand.
- RTbus  in  WIDTH  T operand.
- QCsel  in  4  condition select.
- InTag  in  TAG_W  tag returned with the result.
- OutValid  out  1  Result, OutTag and Illegal are valid.
- OutReady  in  1  consumer accepts the output.
- Result  out  1  condition outcome; 1 means taken.
- OutTag  out  TAG_W  tag of the result.
- Illegal  out  1  QCsel was unencoded.
- StatClr  in  1  clears the statistics counters.
- TakenCnt  out  CNT_W  saturating count of taken results delivered.
- EvalCnt  out  CNT_W  saturating count of results delivered.

## Operation
- QCsel encoding. S is RSbus and T is RTbus; signed compares use two's complement.
  - 0 NE: S!=T. 1 EQ: S==T.
  - 2 LEZ: S[MSB] or S==0. 3 GTZ: !S[MSB] and S!=0.
  - 4 GEZ: !S[MSB]. 5 LTZ: S[MSB].
  - 6 LT: S<T signed. 7 GE: S>=T signed.
  - 8 LTU: S<T unsigned. 9 GEU: S>=T unsigned.
  - 10–15 are illegal: Result=0 and Illegal=1. No don't-care values are allowed.
- Stage 1 captures RSbus, RTbus, QCsel and InTag on an input handshake (InValid & InReady).
- Stage 2 holds the evaluated Result, Illegal and OutTag, all registered. No output is driven combinationally from the inputs.
- An output handshake is OutValid & OutReady.
- Stall rules:
  - Stage 2 advances when it is empty or its output handshake occurs.
  - Stage 1 advances into stage 2 when it is valid and stage 2 advances.
  - InReady = ~Flush & (~S1valid | s2_advance).
- While OutValid=1 and OutReady=0, Result, OutTag and Illegal hold stable.
- Flush=1 clears the S1 and S2 valid bits at the next edge.
  - InReady is 0 in the Flush cycle, so no input is accepted.
  - An output handshake coincident with Flush still counts in the statistics.
- Reset (Reset_n=0 at an edge) has priority over Flush and over every handshake.

## Timing
- Latency is 2 cycles: an input accepted at edge N gives OutValid=1 after edge N+1, when stage 2 is not stalled.
- Throughput is 1 operation per cycle with OutReady held at 1.
- The unit holds at most 2 operations in flight. Back-to-back inputs with OutReady=0 fill both stages, then InReady=0.
- After reset:
  - OutValid=0, Result=0, Illegal=0, OutTag=0.
  - TakenCnt=0, EvalCnt=0.
  - InReady=1 in the first cycle with Reset_n=1 and Flush=0.
- Reset asserted mid-operation discards all in-flight operations. No output handshake occurs in the reset cycle.

## Configuration
- QC_STATS_EN defined:
  - EvalCnt increments on each output handshake; TakenCnt increments when that handshake has Result=1.
  - Both counters saturate at 2^CNT_W-1.
  - StatClr=1 zeroes both counters and takes priority over an increment in the same cycle.
- QC_STATS_EN undefined:
  - No counter logic is built, and StatClr is ignored.
  - TakenCnt and EvalCnt are tied to 0; the ports remain present.

## Test plan
- Reset, then with OutReady=1: issue NE S=5/T=5, then EQ S=5/T=5 back-to-back -> Result 0 then 1, two cycles after each acceptance, and tags preserved.
- WIDTH=32 operand pairs:
  - LT with S=0xFFFFFFFF, T=1 -> 1. LTU with the same operands -> 0.
  - GEU with S=0x80000000, T=0x7FFFFFFF -> 1.
  - LEZ with S=0 -> 1. GTZ with S=0 -> 0.
- Backpressure: hold OutReady=0 and offer 3 inputs -> 2 accepted, then InReady=0 and outputs stable. Release OutReady -> results emerge in order, one per cycle.
- Two operations in flight, Flush=1 for one cycle -> OutValid=0 next cycle and InReady=0 during the flush. A QCsel=12 input afterwards -> Result=0, Illegal=1.
- With QC_STATS_EN and CNT_W=2: deliver 5 taken results -> TakenCnt=EvalCnt=3 (saturated). StatClr -> both 0 even with a coincident handshake. Without QC_STATS_EN -> both 0 throughout.
